irf_reg_bank: RTL and testbench

- Eight-entry, 8-bit integer register file inside IRF. Sits directly downstream of the 1-to-8 write-enable demultiplexer and consumes its one-hot output as per-register write strobes.
- Provides two combinational read ports with same-cycle write bypass and a hardwired-zero R0.
- Adds a pending-load scoreboard that raises a stall while a source register awaits a load writeback.

---
 rtl/irf_reg_bank_pkg.sv | 20 ++
 rtl/irf_reg_bank_scoreboard.sv | 41 ++++
 rtl/irf_reg_bank.sv | 68 ++++++
 tb/tb_irf_reg_bank.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irf_reg_bank_pkg.sv
// Shared IRF definitions: register-file geometry and the write-strobe validity check
// used by both the register bank and the demux checker.
package irf_reg_bank_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NREG     = 2 ** ADDR_W;
    localparam int unsigned ZERO_REG = 0;

    // True only when exactly one strobe bit is set.
    function automatic logic is_onehot(input logic [NREG-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (v[i]) n++;
        end
        return (n == 1);
    endfunction

endpackage

// File: rtl/irf_reg_bank_scoreboard.sv
// Pending-load scoreboard: tracks registers awaiting a load writeback and raises
// stall when a read port sources one that is not being written this cycle.
module irf_scoreboard
    import irf_reg_bank_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREG-1:0]   wr_mask,
    input  logic              ld_issue,
    input  logic [ADDR_W-1:0] ld_dst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [NREG-1:0]   pend,
    output logic              stall
);

    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] pend_nxt;
    logic            stall1;
    logic            stall2;

    // Set is applied after clear so a new load supersedes a completing writeback.
    always_comb begin
        set_mask = '0;
        if (ld_issue && (ld_dst != ADDR_W'(ZERO_REG))) set_mask[ld_dst] = 1'b1;
        pend_nxt = (pend & ~wr_mask) | set_mask;
        pend_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend <= '0;
        else        pend <= pend_nxt;
    end

    always_comb begin
        stall1 = (ra1 != ADDR_W'(ZERO_REG)) && pend[ra1] && !wr_mask[ra1];
        stall2 = (ra2 != ADDR_W'(ZERO_REG)) && pend[ra2] && !wr_mask[ra2];
        stall  = stall1 || stall2;
    end

endmodule

// File: rtl/irf_reg_bank.sv
// Eight-entry integer register file: one-hot strobed writes, two bypassed
// combinational read ports, hardwired-zero R0 and a pending-load scoreboard.
module irf_reg_bank #(
    parameter int unsigned DATA_W = irf_reg_bank_pkg::DATA_W,
    parameter int unsigned ADDR_W = irf_reg_bank_pkg::ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2**ADDR_W-1:0] we_vec,
    input  logic [DATA_W-1:0]    wd,
    input  logic [ADDR_W-1:0]    ra1,
    input  logic [ADDR_W-1:0]    ra2,
    output logic [DATA_W-1:0]    rd1,
    output logic [DATA_W-1:0]    rd2,
    input  logic                 ld_issue,
    input  logic [ADDR_W-1:0]    ld_dst,
    output logic [2**ADDR_W-1:0] pend,
    output logic                 stall,
    output logic                 we_err
);

    import irf_reg_bank_pkg::*;

    logic [DATA_W-1:0] regs [NREG];
    logic              wr_ok;
    logic [NREG-1:0]   wr_mask;

    always_comb begin
        wr_ok   = is_onehot(we_vec);
        wr_mask = wr_ok ? we_vec : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            for (int unsigned i = 1; i < NREG; i++) begin
                if (wr_mask[i]) regs[i] <= wd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        we_err <= 1'b0;
        else if (we_vec != '0 && !wr_ok)   we_err <= 1'b1;
    end

    // A same-cycle valid write to the addressed register is forwarded ahead of storage.
    always_comb begin
        rd1 = '0;
        if (ra1 != ADDR_W'(ZERO_REG)) rd1 = wr_mask[ra1] ? wd : regs[ra1];
        rd2 = '0;
        if (ra2 != ADDR_W'(ZERO_REG)) rd2 = wr_mask[ra2] ? wd : regs[ra2];
    end

    irf_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_mask  (wr_mask),
        .ld_issue (ld_issue),
        .ld_dst   (ld_dst),
        .ra1      (ra1),
        .ra2      (ra2),
        .pend     (pend),
        .stall    (stall)
    );

endmodule

// File: tb/tb_irf_reg_bank.sv
// Self-checking bench for irf_reg_bank: directed scenarios plus randomized traffic
// checked against an array-based reference model.
module tb_irf_reg_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] we_vec;
    logic [7:0] wd;
    logic [2:0] ra1, ra2, ld_dst;
    logic       ld_issue;
    logic [7:0] rd1, rd2, pend;
    logic       stall, we_err;

    int total = 0;
    int bad   = 0;

    bit [7:0] mreg [8];
    bit [7:0] mpend;
    bit       merr;

    irf_reg_bank #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_vec   (we_vec),
        .wd       (wd),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .ld_issue (ld_issue),
        .ld_dst   (ld_dst),
        .pend     (pend),
        .stall    (stall),
        .we_err   (we_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit valid_we();
        return $countones(we_vec) == 1;
    endfunction

    function automatic bit [7:0] exp_rd(input bit [2:0] a);
        if (a == 0) return 8'h00;
        if (valid_we() && we_vec[a]) return wd;
        return mreg[a];
    endfunction

    function automatic bit exp_stall_port(input bit [2:0] a);
        return (a != 0) && mpend[a] && !(valid_we() && we_vec[a]);
    endfunction

    function automatic bit exp_stall();
        return exp_stall_port(ra1) || exp_stall_port(ra2);
    endfunction

    task automatic idle_inputs();
        we_vec = 8'h00; wd = 8'h00; ra1 = 3'd0; ra2 = 3'd0;
        ld_issue = 1'b0; ld_dst = 3'd0;
    endtask

    task automatic model_clear();
        foreach (mreg[i]) mreg[i] = 8'h00;
        mpend = 8'h00;
        merr  = 1'b0;
    endtask

    // One rising edge; the model applies the inputs the DUT sampled there.
    task automatic tick();
        @(posedge clk);
        if (valid_we()) begin
            for (int i = 1; i < 8; i++) begin
                if (we_vec[i]) begin
                    mreg[i]  = wd;
                    mpend[i] = 1'b0;
                end
            end
        end else if (we_vec != 8'h00) begin
            merr = 1'b1;
        end
        if (ld_issue && ld_dst != 3'd0) mpend[ld_dst] = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int a = 0; a < 8; a++) begin
            ra1 = 3'(a); ra2 = 3'(7 - a);
            #1;
            total++;
            if (rd1 !== 8'h00 || rd2 !== 8'h00 || stall !== 1'b0) begin
                bad++;
                $display("FAIL reset_read a=%0d: rd1=%h rd2=%h stall=%b required 00 00 0", a, rd1, rd2, stall);
            end
        end
        total++;
        if (pend !== 8'h00 || we_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: pend=%h we_err=%b required 00 0", pend, we_err);
        end
    endtask

    task automatic test_write();
        tick();
        we_vec = 8'h08; wd = 8'hA5; ra2 = 3'd3; ra1 = 3'd0;
        #2;
        total++;
        if (rd2 !== 8'hA5) begin
            bad++;
            $display("FAIL write_bypass: rd2=%h required a5", rd2);
        end
        tick();
        we_vec = 8'h00; ra1 = 3'd3; ra2 = 3'd0;
        #2;
        total++;
        if (rd1 !== 8'hA5) begin
            bad++;
            $display("FAIL write_stored: rd1=%h required a5", rd1);
        end
    endtask

    task automatic test_r0();
        tick();
        we_vec = 8'h01; wd = 8'hFF; ra1 = 3'd0;
        #2;
        total++;
        if (rd1 !== 8'h00) begin
            bad++;
            $display("FAIL r0_bypass: rd1=%h required 00", rd1);
        end
        tick();
        we_vec = 8'h00;
        #2;
        total++;
        if (rd1 !== 8'h00 || we_err !== 1'b0) begin
            bad++;
            $display("FAIL r0_write: rd1=%h we_err=%b required 00 0", rd1, we_err);
        end
    endtask

    task automatic test_multihot();
        tick();
        we_vec = 8'h04; wd = 8'h11;
        tick();
        we_vec = 8'h0C; wd = 8'h3C; ra1 = 3'd2; ra2 = 3'd3;
        #2;
        total++;
        if (rd1 !== 8'h11 || rd2 !== 8'hA5) begin
            bad++;
            $display("FAIL multihot_no_bypass: rd1=%h rd2=%h required 11 a5", rd1, rd2);
        end
        tick();
        we_vec = 8'h00;
        #2;
        total++;
        if (rd1 !== 8'h11 || rd2 !== 8'hA5 || we_err !== 1'b1) begin
            bad++;
            $display("FAIL multihot: rd1=%h rd2=%h we_err=%b required 11 a5 1", rd1, rd2, we_err);
        end
        we_vec = 8'h40; wd = 8'h22;
        tick();
        we_vec = 8'h00;
        tick(); tick();
        total++;
        if (we_err !== 1'b1) begin
            bad++;
            $display("FAIL we_err_sticky: we_err=%b required 1", we_err);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (we_err !== 1'b0 || rd1 !== 8'h00 || rd2 !== 8'h00) begin
            bad++;
            $display("FAIL we_err_reset: we_err=%b rd1=%h rd2=%h required 0 00 00", we_err, rd1, rd2);
        end
        idle_inputs();
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_scoreboard();
        tick();
        ld_issue = 1'b1; ld_dst = 3'd5;
        tick();
        ld_issue = 1'b0; ra1 = 3'd5;
        #2;
        total++;
        if (pend !== 8'h20 || stall !== 1'b1) begin
            bad++;
            $display("FAIL load_pending: pend=%h stall=%b required 20 1", pend, stall);
        end
        tick();
        we_vec = 8'h20; wd = 8'h77;
        #2;
        total++;
        if (stall !== 1'b0 || rd1 !== 8'h77) begin
            bad++;
            $display("FAIL load_writeback: stall=%b rd1=%h required 0 77", stall, rd1);
        end
        tick();
        we_vec = 8'h00;
        #2;
        total++;
        if (pend !== 8'h00 || stall !== 1'b0 || rd1 !== 8'h77) begin
            bad++;
            $display("FAIL load_cleared: pend=%h stall=%b rd1=%h required 00 0 77", pend, stall, rd1);
        end
    endtask

    task automatic test_set_clear();
        tick();
        ld_issue = 1'b1; ld_dst = 3'd4;
        tick();
        we_vec = 8'h10; wd = 8'h5A;
        tick();
        idle_inputs();
        ra1 = 3'd4;
        #2;
        total++;
        if (rd1 !== 8'h5A || pend !== 8'h10 || stall !== 1'b1) begin
            bad++;
            $display("FAIL set_wins: rd1=%h pend=%h stall=%b required 5a 10 1", rd1, pend, stall);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (pend !== 8'h00 || rd1 !== 8'h00 || stall !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: pend=%h rd1=%h stall=%b required 00 00 0", pend, rd1, stall);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            tick();
            r = int'($urandom_range(0, 19));
            if (r < 10)      we_vec = 8'h01 << $urandom_range(0, 7);
            else if (r < 19) we_vec = 8'h00;
            else             we_vec = 8'($urandom) | 8'h81;
            wd       = 8'($urandom);
            ra1      = 3'($urandom);
            ra2      = 3'($urandom);
            ld_issue = ($urandom_range(0, 2) == 0);
            ld_dst   = 3'($urandom);
            #2;
            total++;
            if (rd1 !== exp_rd(ra1) || rd2 !== exp_rd(ra2) || stall !== exp_stall()
                || pend !== mpend || we_err !== merr) begin
                bad++;
                $display("FAIL random[%0d]: rd1=%h rd2=%h stall=%b pend=%h we_err=%b required %h %h %b %h %b",
                         n, rd1, rd2, stall, pend, we_err,
                         exp_rd(ra1), exp_rd(ra2), exp_stall(), mpend, merr);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_clear();
        test_reset();
        test_write();
        test_r0();
        test_multihot();
        test_scoreboard();
        test_set_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
